// File: rtl/fetch_sequencer.sv
// PC / IF-ID sequencing controller: stalls, redirect squash and halt drain.
// Optional perf counters are built only when FETCH_PERF_EN is defined.
module fetch_sequencer #(
   parameter int FLUSH_CYCLES = 1,
   parameter int DRAIN_CYCLES = 3
) (
   input  logic        CLK,
   input  logic        nRST,
   input  logic        ihit,
   input  logic        dhit,
   input  logic        dmem_req,
   input  logic        load_stall,
   input  logic        jump_req,
   input  logic        branch_taken,
   input  logic        halt_req,
   output logic        pcEN,
   output logic        jumpmux,
   output logic        branchmux,
   output logic        ifid_en,
   output logic        ifid_flush,
   output logic        halted,
   output logic [31:0] stall_cnt,
   output logic [31:0] flush_cnt
);

   typedef enum logic [2:0] {IDLE, FETCH, MEMWAIT, FLUSH, DRAIN, HALT} state_t;

   localparam logic [2:0] FLUSH_LD = 3'(FLUSH_CYCLES - 1);
   localparam logic [3:0] DRAIN_LD = 4'(DRAIN_CYCLES);

   state_t     state, nxt_state;
   logic [2:0] fcnt, nxt_fcnt;
   logic [3:0] dcnt, nxt_dcnt;
   logic       mem_pend;

   assign mem_pend = dmem_req & ~dhit;

   always_comb begin
      nxt_state  = state;
      nxt_fcnt   = fcnt;
      nxt_dcnt   = dcnt;
      pcEN       = 1'b0;
      jumpmux    = 1'b0;
      branchmux  = 1'b0;
      ifid_en    = 1'b0;
      ifid_flush = 1'b0;
      case (state)
         IDLE: nxt_state = FETCH;
         FETCH: begin
            if (mem_pend) begin
               nxt_state = MEMWAIT;
            end else if (halt_req) begin
               ifid_flush = 1'b1;
               nxt_dcnt   = DRAIN_LD;
               nxt_state  = DRAIN;
            end else if (load_stall || !ihit) begin
               nxt_state = FETCH;
            end else if (jump_req || branch_taken) begin
               pcEN       = 1'b1;
               jumpmux    = jump_req;
               branchmux  = branch_taken & ~jump_req;
               ifid_flush = 1'b1;
               nxt_fcnt   = FLUSH_LD;
               if (FLUSH_CYCLES > 1) nxt_state = FLUSH;
            end else begin
               pcEN    = 1'b1;
               ifid_en = 1'b1;
            end
         end
         MEMWAIT: if (dhit) nxt_state = FETCH;
         // wrong-path redirect/halt requests are ignored while squashing
         FLUSH: begin
            ifid_flush = 1'b1;
            pcEN       = ihit;
            if (ihit) begin
               nxt_fcnt = fcnt - 3'd1;
               if (fcnt <= 3'd1) nxt_state = FETCH;
            end
         end
         DRAIN: begin
            ifid_flush = 1'b1;
            if (!mem_pend) begin
               nxt_dcnt = dcnt - 4'd1;
               if (dcnt <= 4'd1) nxt_state = HALT;
            end
         end
         HALT:    nxt_state = HALT;
         default: nxt_state = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state  <= IDLE;
         fcnt   <= '0;
         dcnt   <= '0;
         halted <= 1'b0;
      end else begin
         state  <= nxt_state;
         fcnt   <= nxt_fcnt;
         dcnt   <= nxt_dcnt;
         halted <= halted | (nxt_state == HALT);
      end
   end

`ifdef FETCH_PERF_EN
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else if (state != HALT) begin
         if ((state == FETCH || state == MEMWAIT) && !pcEN) stall_cnt <= stall_cnt + 32'd1;
         if (ifid_flush && state != DRAIN) flush_cnt <= flush_cnt + 32'd1;
      end
   end
`else
   assign stall_cnt = '0;
   assign flush_cnt = '0;
`endif

endmodule
